// File: rtl/dco_tune_pkg.sv
// Shared types and constants for the DCO tuning controller and its thermometer encoder.
package dco_tune_pkg;

  localparam int DCO_CODE_W     = 129;
  localparam int IDX_W          = 8;
  localparam int MAX_INDEX_DEF  = 128;
  localparam int INIT_INDEX_DEF = 64;
  localparam int LOCK_COUNT_DEF = 16;
  localparam int UNLOCK_RUN_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2,
    ST_LOCKED = 2'd3
  } tune_state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  // Move an index by amt towards up/down, clamped to [0, max_idx].
  function automatic logic [IDX_W-1:0] idx_move(input logic [IDX_W-1:0] idx,
                                                 input logic             up,
                                                 input logic [IDX_W-1:0] amt,
                                                 input logic [IDX_W-1:0] max_idx);
    logic [IDX_W:0] sum;
    if (up) begin
      sum = {1'b0, idx} + {1'b0, amt};
      if (sum > {1'b0, max_idx}) sum = {1'b0, max_idx};
    end else if (amt > idx) begin
      sum = '0;
    end else begin
      sum = {1'b0, idx - amt};
    end
    return sum[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/dco_therm_encoder.sv
// Combinational index -> thermometer code: code[i] = (i < index). The parent registers the result.
module dco_therm_encoder
  import dco_tune_pkg::*;
#(
  parameter int CODE_W = DCO_CODE_W
) (
  input  logic [IDX_W-1:0]  index,
  output logic [CODE_W-1:0] code
);

  for (genvar gi = 0; gi < CODE_W; gi++) begin : g_bit
    localparam logic [IDX_W:0] POS = (IDX_W + 1)'(gi);
    assign code[gi] = (POS < {1'b0, index});
  end

endmodule

// File: rtl/dco_tune_controller.sv
// Bang-bang DCO tuning loop: 7-decision binary search, then +/-1 tracking with lock detection.
// Optional manual index override is compiled in when DCO_TUNE_MANUAL_EN is defined.
module dco_tune_controller
  import dco_tune_pkg::*;
#(
  parameter int MAX_INDEX  = MAX_INDEX_DEF,
  parameter int INIT_INDEX = INIT_INDEX_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int UNLOCK_RUN = UNLOCK_RUN_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              PD_VALID,
  input  logic              PD_UP,
  input  logic              PD_DN,
`ifdef DCO_TUNE_MANUAL_EN
  input  logic              MANUAL,
  input  logic [IDX_W-1:0]  MANUAL_INDEX,
`endif
  output logic [MAX_INDEX:0] code,
  output logic [IDX_W-1:0]  code_index,
  output logic [1:0]        state,
  output logic              LOCKED
);

  localparam int ALT_W = $clog2(LOCK_COUNT + 1);
  localparam int RUN_W = $clog2(UNLOCK_RUN + 1);
  localparam logic [IDX_W-1:0] INIT_IDX   = IDX_W'(INIT_INDEX);
  localparam logic [IDX_W-1:0] MAX_IDX    = IDX_W'(MAX_INDEX);
  localparam logic [IDX_W-1:0] INIT_STEP  = IDX_W'(INIT_INDEX / 2);
  localparam logic [ALT_W-1:0] LOCK_CNT   = ALT_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] UNLOCK_CNT = RUN_W'(UNLOCK_RUN);

  tune_state_t        state_reg;
  dir_t               last_dir_reg;
  dir_t               dec_dir;
  logic [IDX_W-1:0]   index_reg, index_next;
  logic [IDX_W-1:0]   step_reg;
  logic               last_step_reg;
  logic [ALT_W-1:0]   alt_cnt_reg, alt_inc;
  logic [RUN_W-1:0]   run_cnt_reg, run_inc;
  logic               locked_reg;
  logic [MAX_INDEX:0] code_reg, therm_code;
  logic [IDX_W-1:0]   move_amt;
  logic               dec_valid;
  logic               force_idle;

`ifdef DCO_TUNE_MANUAL_EN
  logic manual_prev_reg;

  always_ff @(posedge CLK) begin
    if (RESET) manual_prev_reg <= 1'b0;
    else       manual_prev_reg <= MANUAL;
  end
`endif

  always_comb begin
    dec_valid = PD_VALID && (PD_UP ^ PD_DN);
    dec_dir   = PD_UP ? DIR_UP : DIR_DN;
    alt_inc   = (dec_dir != last_dir_reg)
              ? ((alt_cnt_reg == LOCK_CNT) ? alt_cnt_reg : alt_cnt_reg + ALT_W'(1))
              : ALT_W'(1);
    run_inc   = (dec_dir == last_dir_reg)
              ? ((run_cnt_reg == UNLOCK_CNT) ? run_cnt_reg : run_cnt_reg + RUN_W'(1))
              : RUN_W'(1);
    move_amt  = (state_reg == ST_COARSE) ? step_reg : IDX_W'(1);
    force_idle = !ENABLE;
`ifdef DCO_TUNE_MANUAL_EN
    force_idle = force_idle || MANUAL;
`endif

    index_next = index_reg;
    if (RESET || force_idle) begin
      index_next = INIT_IDX;
    end else if (dec_valid && (state_reg != ST_IDLE)) begin
      index_next = idx_move(index_reg, PD_UP, move_amt, MAX_IDX);
    end
`ifdef DCO_TUNE_MANUAL_EN
    // Manual override pins the index; releasing it restarts acquisition from the initial index.
    if (!RESET) begin
      if (MANUAL) index_next = (MANUAL_INDEX > MAX_IDX) ? MAX_IDX : MANUAL_INDEX;
      else if (manual_prev_reg) index_next = INIT_IDX;
    end
`endif
  end

  dco_therm_encoder #(.CODE_W(MAX_INDEX + 1)) u_therm (
    .index (index_next),
    .code  (therm_code)
  );

  // index_next already folds in reset, so the datapath registers need no separate reset branch.
  always_ff @(posedge CLK) begin
    index_reg <= index_next;
    code_reg  <= therm_code;
  end

  always_ff @(posedge CLK) begin
    if (RESET || force_idle) begin
      state_reg     <= ST_IDLE;
      step_reg      <= INIT_STEP;
      last_step_reg <= 1'b0;
      alt_cnt_reg   <= '0;
      run_cnt_reg   <= '0;
      last_dir_reg  <= DIR_NONE;
      locked_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg     <= ST_COARSE;
          step_reg      <= INIT_STEP;
          last_step_reg <= 1'b0;
        end
        ST_COARSE: begin
          // Step sequence 32,16,8,4,2,1,1: the repeated unit step gives the seventh decision.
          if (dec_valid) begin
            if (step_reg == IDX_W'(1)) begin
              if (last_step_reg) begin
                state_reg    <= ST_FINE;
                alt_cnt_reg  <= '0;
                run_cnt_reg  <= '0;
                last_dir_reg <= DIR_NONE;
              end else begin
                last_step_reg <= 1'b1;
              end
            end else begin
              step_reg <= step_reg >> 1;
            end
          end
        end
        ST_FINE: begin
          if (dec_valid) begin
            last_dir_reg <= dec_dir;
            alt_cnt_reg  <= alt_inc;
            if (alt_inc == LOCK_CNT) begin
              state_reg   <= ST_LOCKED;
              locked_reg  <= 1'b1;
              run_cnt_reg <= RUN_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (dec_valid) begin
            last_dir_reg <= dec_dir;
            if (run_inc == UNLOCK_CNT) begin
              state_reg   <= ST_FINE;
              locked_reg  <= 1'b0;
              alt_cnt_reg <= '0;
              run_cnt_reg <= '0;
            end else begin
              run_cnt_reg <= run_inc;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign code       = code_reg;
  assign code_index = index_reg;
  assign state      = state_reg;
  assign LOCKED     = locked_reg;

endmodule

// File: tb/tb_dco_tune_controller.sv
// Self-checking bench for dco_tune_controller: directed scenarios plus randomized decisions vs a reference model.
module tb_dco_tune_controller;

  logic         CLK = 1'b0;
  logic         RESET, ENABLE, PD_VALID, PD_UP, PD_DN;
  logic [128:0] code;
  logic [7:0]   code_index;
  logic [1:0]   state;
  logic         LOCKED;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

`ifdef DCO_TUNE_MANUAL_EN
  logic       MANUAL = 1'b0;
  logic [7:0] MANUAL_INDEX = 8'd0;
`endif

  dco_tune_controller dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .PD_VALID   (PD_VALID),
    .PD_UP      (PD_UP),
    .PD_DN      (PD_DN),
`ifdef DCO_TUNE_MANUAL_EN
    .MANUAL       (MANUAL),
    .MANUAL_INDEX (MANUAL_INDEX),
`endif
    .code       (code),
    .code_index (code_index),
    .state      (state),
    .LOCKED     (LOCKED)
  );

  // Reference model: state 0..3, index, decisions spent in acquisition, direction history (+1/-1).
  int m_state = 0;
  int m_index = 64;
  int m_ncoarse = 0;
  int hist[$];

  function automatic logic [128:0] exp_code(input int idx);
    logic [128:0] c;
    c = '0;
    for (int i = 0; i < 128; i++) if (i < idx) c[i] = 1'b1;
    return c;
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 128) ? 128 : v);
  endfunction

  // Length of the alternating run at the tail of hist.
  function automatic int trail_alt();
    int n;
    if (hist.size() == 0) return 0;
    n = 1;
    for (int i = hist.size() - 1; i > 0; i--) begin
      if (hist[i] != hist[i-1]) n++;
      else break;
    end
    return n;
  endfunction

  // Length of the same-direction run at the tail of hist.
  function automatic int trail_same();
    int n;
    if (hist.size() == 0) return 0;
    n = 1;
    for (int i = hist.size() - 1; i > 0; i--) begin
      if (hist[i] == hist[i-1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit v, input bit up, input bit dn);
    bit dec;
    int dir;
    int amt;
    dec = v && (up != dn);
    dir = up ? 1 : -1;
    if (rst || !en) begin
      m_state = 0; m_index = 64; m_ncoarse = 0; hist.delete();
      return;
    end
    case (m_state)
      0: begin m_state = 1; m_ncoarse = 0; end
      1: if (dec) begin
        amt = (m_ncoarse < 6) ? (32 >> m_ncoarse) : 1;
        m_index = clamp(m_index + dir * amt);
        m_ncoarse++;
        if (m_ncoarse == 7) begin m_state = 2; hist.delete(); end
      end
      2: if (dec) begin
        m_index = clamp(m_index + dir);
        hist.push_back(dir);
        if (trail_alt() >= 16) begin m_state = 3; hist.delete(); hist.push_back(dir); end
      end
      default: if (dec) begin
        m_index = clamp(m_index + dir);
        hist.push_back(dir);
        if (trail_same() >= 4) begin m_state = 2; hist.delete(); end
      end
    endcase
  endtask

  task automatic step_clk(input bit rst, input bit en, input bit v, input bit up, input bit dn);
    RESET = rst; ENABLE = en; PD_VALID = v; PD_UP = up; PD_DN = dn;
    @(posedge CLK);
    model_step(rst, en, v, up, dn);
    #1;
  endtask

  task automatic decide(input bit up);
    step_clk(1'b0, 1'b1, 1'b1, up, !up);
  endtask

  task automatic restart();
    step_clk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step_clk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step_clk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step_clk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (code_index !== 8'd64 || state !== 2'd0 || LOCKED !== 1'b0 || code !== exp_code(64)) begin
      n_err++;
      $display("FAIL reset_hold: index=%0d state=%0d locked=%0b, required index=64 state=0 locked=0 with 64-ones code",
               code_index, state, LOCKED);
    end
    step_clk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (code_index !== 8'd64 || state !== 2'd1 || LOCKED !== 1'b0 || code !== exp_code(64)) begin
      n_err++;
      $display("FAIL reset_release: index=%0d state=%0d locked=%0b, required index=64 state=1 locked=0",
               code_index, state, LOCKED);
    end
  endtask

  task automatic test_binary_search();
    int exp_idx[7];
    bit dirs[7];
    bit r;
    exp_idx = '{96, 112, 104, 100, 102, 103, 104};
    dirs    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    restart();
    for (int k = 0; k < 7; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        r = 1'($urandom_range(0, 1));
        step_clk(1'b0, 1'b1, 1'b0, r, !r);
      end
      decide(dirs[k]);
      n_vec++;
      if (code_index !== 8'(exp_idx[k]) || state !== ((k == 6) ? 2'd2 : 2'd1) || code !== exp_code(exp_idx[k])) begin
        n_err++;
        $display("FAIL search_100 step %0d: index=%0d state=%0d, required index=%0d state=%0d",
                 k, code_index, state, exp_idx[k], (k == 6) ? 2 : 1);
      end
    end
    for (int t = 0; t < 6; t++) begin
      restart();
      for (int k = 0; k < 7; k++) begin
        decide(1'($urandom_range(0, 1)));
        n_vec++;
        if (code_index !== 8'(m_index) || state !== 2'(m_state) || code !== exp_code(m_index)) begin
          n_err++;
          $display("FAIL search_rand run %0d step %0d: index=%0d state=%0d, required index=%0d state=%0d",
                   t, k, code_index, state, m_index, m_state);
        end
      end
      n_vec++;
      if (state !== 2'd2) begin
        n_err++;
        $display("FAIL search_exit run %0d: state=%0d, required 2", t, state);
      end
    end
  endtask

  task automatic test_lock();
    bit dirs[7];
    dirs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    restart();
    for (int k = 0; k < 7; k++) decide(dirs[k]);
    for (int i = 0; i < 16; i++) begin
      decide(i % 2 == 0);
      n_vec++;
      if (LOCKED !== (i == 15) || state !== ((i == 15) ? 2'd3 : 2'd2) || code_index !== ((i % 2 == 0) ? 8'd105 : 8'd104)) begin
        n_err++;
        $display("FAIL lock_alt %0d: locked=%0b state=%0d index=%0d, required locked=%0b state=%0d index=%0d",
                 i, LOCKED, state, code_index, (i == 15), (i == 15) ? 3 : 2, (i % 2 == 0) ? 105 : 104);
      end
    end
    for (int i = 0; i < 4; i++) begin
      decide(1'b1);
      n_vec++;
      if (LOCKED !== (i < 3) || state !== ((i < 3) ? 2'd3 : 2'd2) || code_index !== 8'(105 + i)) begin
        n_err++;
        $display("FAIL unlock_run %0d: locked=%0b state=%0d index=%0d, required locked=%0b state=%0d index=%0d",
                 i, LOCKED, state, code_index, (i < 3), (i < 3) ? 3 : 2, 105 + i);
      end
    end
  endtask

  task automatic test_saturation();
    restart();
    for (int k = 0; k < 7; k++) decide(1'b1);
    n_vec++;
    if (code_index !== 8'd128 || state !== 2'd2) begin
      n_err++;
      $display("FAIL sat_top_reach: index=%0d state=%0d, required 128/2", code_index, state);
    end
    for (int i = 0; i < 5; i++) begin
      decide(1'b1);
      n_vec++;
      if (code_index !== 8'd128 || code[128] !== 1'b0 || code !== exp_code(128) || state !== 2'd2) begin
        n_err++;
        $display("FAIL sat_top %0d: index=%0d code128=%0b state=%0d, required 128/0/2", i, code_index, code[128], state);
      end
    end
    step_clk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step_clk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) decide(1'b0);
    for (int i = 0; i < 3; i++) begin
      decide(1'b0);
      n_vec++;
      if (code_index !== 8'd0 || code !== '0 || state !== 2'd2) begin
        n_err++;
        $display("FAIL sat_bottom %0d: index=%0d state=%0d, required 0/2 with all-zero code", i, code_index, state);
      end
    end
  endtask

  task automatic test_hold();
    int idx0;
    int st0;
    bit r;
    restart();
    for (int phase = 0; phase < 2; phase++) begin
      for (int k = 0; k < ((phase == 0) ? 3 : 4); k++) decide(1'($urandom_range(0, 1)));
      idx0 = m_index;
      st0  = m_state;
      for (int i = 0; i < 8; i++) begin
        r = 1'($urandom_range(0, 1));
        if (i % 2 == 0) step_clk(1'b0, 1'b1, 1'b1, r, r);
        else            step_clk(1'b0, 1'b1, 1'b0, r, !r);
        n_vec++;
        if (code_index !== 8'(idx0) || state !== 2'(st0) || code !== exp_code(idx0)) begin
          n_err++;
          $display("FAIL hold phase %0d cyc %0d: index=%0d state=%0d, required %0d/%0d", phase, i, code_index, state, idx0, st0);
        end
      end
    end
  endtask

  task automatic test_abort();
    restart();
    for (int k = 0; k < 3; k++) decide(1'($urandom_range(0, 1)));
    step_clk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (code_index !== 8'd64 || state !== 2'd0 || LOCKED !== 1'b0 || code !== exp_code(64)) begin
      n_err++;
      $display("FAIL abort_enable: index=%0d state=%0d locked=%0b, required 64/0/0", code_index, state, LOCKED);
    end
    step_clk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) decide(1'($urandom_range(0, 1)));
    for (int i = 0; i < 16; i++) decide(i % 2 == 1);
    n_vec++;
    if (LOCKED !== 1'b1 || state !== 2'd3) begin
      n_err++;
      $display("FAIL abort_prelock: locked=%0b state=%0d, required 1/3", LOCKED, state);
    end
    step_clk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (code_index !== 8'd64 || state !== 2'd0 || LOCKED !== 1'b0 || code !== exp_code(64)) begin
      n_err++;
      $display("FAIL abort_reset: index=%0d state=%0d locked=%0b, required 64/0/0", code_index, state, LOCKED);
    end
  endtask

  task automatic test_random();
    bit alt_mode;
    bit last_up;
    bit rst, en, v, up, dn;
    alt_mode = 1'b0;
    last_up  = 1'b0;
    restart();
    for (int c = 0; c < 1500; c++) begin
      if (c % 40 == 0) alt_mode = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 79) != 0);
      v   = ($urandom_range(0, 9) < 7);
      up  = alt_mode ? !last_up : 1'($urandom_range(0, 1));
      dn  = ($urandom_range(0, 15) == 0) ? up : !up;
      if (v && (up != dn)) last_up = up;
      step_clk(rst, en, v, up, dn);
      n_vec++;
      if (code_index !== 8'(m_index) || state !== 2'(m_state) || LOCKED !== (m_state == 3) || code !== exp_code(m_index)) begin
        n_err++;
        $display("FAIL random cyc %0d: index=%0d state=%0d locked=%0b, required index=%0d state=%0d locked=%0b",
                 c, code_index, state, LOCKED, m_index, m_state, (m_state == 3));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; PD_VALID = 1'b0; PD_UP = 1'b0; PD_DN = 1'b0;
    test_reset();
    test_binary_search();
    test_lock();
    test_saturation();
    test_hold();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
